fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that locks the FIFO write port to one requester per burst.
// A burst ends on reqLast or when MaxBurst words have been written.
module fifo_wr_arbiter #(
  parameter int DataWidth = 64,
  parameter int NumReq    = 4,
  parameter int MaxBurst  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumReq-1:0]             reqValid,
  input  logic [NumReq*DataWidth-1:0]   reqData,
  input  logic [NumReq-1:0]             reqLast,
  output logic [NumReq-1:0]             reqReady,
  input  logic                          full,
  output logic                          writeEn,
  output logic [DataWidth-1:0]          writeData,
  output logic [$clog2(NumReq)-1:0]     grantIdx,
  output logic                          busy,
  output logic                          burstErr
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              burst_err_q, burst_err_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  int                cand;
  logic              owner_valid;
  logic              owner_last;
  logic [DataWidth-1:0] owner_data;
  logic [CntW-1:0]   cnt_inc;

  // Scan starting just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = (int'(last_grant_q) + i) % NumReq;
      if (!pick_found && reqValid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_valid = reqValid[i];
        owner_last  = reqLast[i];
        owner_data  = reqData[i*DataWidth +: DataWidth];
      end
    end
  end

  // Outputs are gated by rst so they read idle even while a stale LOCK is still registered.
  always_comb begin
    reqReady  = '0;
    writeEn   = 1'b0;
    writeData = '0;
    grantIdx  = '0;
    busy      = 1'b0;
    burstErr  = burst_err_q && !rst;
    if (state_q == LOCK && !rst) begin
      busy     = 1'b1;
      grantIdx = owner_q;
      for (int i = 0; i < NumReq; i++) begin
        if (owner_q == IdxW'(i)) reqReady[i] = !full;
      end
      writeEn = owner_valid && !full;
      if (writeEn) writeData = owner_data;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    burst_err_d  = burst_err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCK;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        if (writeEn) begin
          cnt_d = cnt_inc;
          if (owner_last) begin
            state_d      = IDLE;
            last_grant_d = owner_q;
          end else if (cnt_inc == CntW'(MaxBurst)) begin
            state_d      = IDLE;
            last_grant_d = owner_q;
            burst_err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NumReq - 1);
      cnt_q        <= '0;
      burst_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      burst_err_q  <= burst_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: four requesters, 16-bit words, MaxBurst of 4.
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   reqValid;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]   reqLast;
  logic [NR-1:0]   reqReady;
  logic            full;
  logic            writeEn;
  logic [DW-1:0]   writeData;
  logic [1:0]      grantIdx;
  logic            busy;
  logic            burstErr;

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .MaxBurst(MB)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqReady(reqReady), .full(full), .writeEn(writeEn), .writeData(writeData),
    .grantIdx(grantIdx), .busy(busy), .burstErr(burstErr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; reqValid = '0; reqData = '0; reqLast = '0; full = 1'b0;
    tick();
    checks++; if (writeEn !== 1'b0) begin failures++; $display("FAIL rst_we got=%0d exp=0", writeEn); end
    checks++; if (reqReady !== 4'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", reqReady); end
    checks++; if (writeData !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", writeData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if (grantIdx !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d exp=0", grantIdx); end
    checks++; if (burstErr !== 1'b0) begin failures++; $display("FAIL rst_err got=%0d exp=0", burstErr); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || writeEn !== 1'b0) begin failures++; $display("FAIL post_rst busy=%0d we=%0d exp=0,0", busy, writeEn); end
  endtask

  task automatic test_priority;
    reqValid = 4'b0101; reqLast = 4'b0101;
    reqData[0*DW +: DW] = 16'h1000; reqData[2*DW +: DW] = 16'h3002;
    #1;
    checks++; if (reqReady !== 4'b0 || writeEn !== 1'b0) begin failures++; $display("FAIL idle_no_xfer ready=%b we=%0d exp=0000,0", reqReady, writeEn); end
    tick();
    checks++; if (busy !== 1'b1 || grantIdx !== 2'd0) begin failures++; $display("FAIL prio_first busy=%0d grant=%0d exp=1,0", busy, grantIdx); end
    checks++; if (reqReady !== 4'b0001 || writeEn !== 1'b1 || writeData !== 16'h1000) begin failures++; $display("FAIL prio_xfer0 ready=%b we=%0d data=%h exp=0001,1,1000", reqReady, writeEn, writeData); end
    tick();
    reqValid = 4'b0100; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_release busy=%0d exp=0", busy); end
    tick();
    checks++; if (grantIdx !== 2'd2 || writeData !== 16'h3002) begin failures++; $display("FAIL prio_second grant=%0d data=%h exp=2,3002", grantIdx, writeData); end
    tick();
    reqValid = '0; reqLast = '0; #1;
  endtask

  task automatic test_burst;
    reqValid = 4'b0010; reqLast = 4'b0000; reqData[1*DW +: DW] = 16'hAAAA;
    tick();
    checks++; if (grantIdx !== 2'd1 || writeEn !== 1'b1 || writeData !== 16'hAAAA) begin failures++; $display("FAIL burst_A grant=%0d we=%0d data=%h exp=1,1,aaaa", grantIdx, writeEn, writeData); end
    tick();
    reqData[1*DW +: DW] = 16'hBBBB; #1;
    checks++; if (writeEn !== 1'b1 || writeData !== 16'hBBBB) begin failures++; $display("FAIL burst_B we=%0d data=%h exp=1,bbbb", writeEn, writeData); end
    tick();
    reqValid = 4'b0000; #1;
    checks++; if (busy !== 1'b1 || writeEn !== 1'b0 || writeData !== 16'h0) begin failures++; $display("FAIL burst_gap busy=%0d we=%0d data=%h exp=1,0,0000", busy, writeEn, writeData); end
    tick();
    reqValid = 4'b0010; reqLast = 4'b0010; reqData[1*DW +: DW] = 16'hCCCC; #1;
    checks++; if (writeEn !== 1'b1 || writeData !== 16'hCCCC) begin failures++; $display("FAIL burst_C we=%0d data=%h exp=1,cccc", writeEn, writeData); end
    tick();
    reqValid = '0; reqLast = '0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_end busy=%0d exp=0", busy); end
  endtask

  task automatic test_full;
    full = 1'b1; reqValid = 4'b1000; reqLast = 4'b1000; reqData[3*DW +: DW] = 16'hD00D;
    tick();
    checks++; if (busy !== 1'b1 || grantIdx !== 2'd3) begin failures++; $display("FAIL full_grant busy=%0d grant=%0d exp=1,3", busy, grantIdx); end
    checks++; if (writeEn !== 1'b0 || reqReady !== 4'b0 || writeData !== 16'h0) begin failures++; $display("FAIL full_stall we=%0d ready=%b data=%h exp=0,0000,0000", writeEn, reqReady, writeData); end
    tick();
    checks++; if (busy !== 1'b1 || writeEn !== 1'b0) begin failures++; $display("FAIL full_hold busy=%0d we=%0d exp=1,0", busy, writeEn); end
    full = 1'b0; #1;
    checks++; if (writeEn !== 1'b1 || reqReady !== 4'b1000 || writeData !== 16'hD00D) begin failures++; $display("FAIL full_resume we=%0d ready=%b data=%h exp=1,1000,d00d", writeEn, reqReady, writeData); end
    tick();
    reqValid = '0; reqLast = '0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_end busy=%0d exp=0", busy); end
  endtask

  task automatic test_max_burst;
    reqValid = 4'b0001; reqLast = 4'b0000;
    tick();
    for (int k = 0; k < MB; k++) begin
      reqData[0*DW +: DW] = 16'h0E00 + 16'(k); #1;
      checks++; if (writeEn !== 1'b1 || writeData !== 16'h0E00 + 16'(k)) begin failures++; $display("FAIL maxb_word%0d we=%0d data=%h exp=1,%h", k, writeEn, writeData, 16'h0E00 + 16'(k)); end
      tick();
    end
    reqValid = '0; #1;
    checks++; if (busy !== 1'b0 || burstErr !== 1'b1) begin failures++; $display("FAIL maxb_release busy=%0d err=%0d exp=0,1", busy, burstErr); end
    tick(); tick();
    checks++; if (burstErr !== 1'b1) begin failures++; $display("FAIL maxb_sticky err=%0d exp=1", burstErr); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (burstErr !== 1'b0) begin failures++; $display("FAIL maxb_clear err=%0d exp=0", burstErr); end
    reqValid = 4'b0001;
    tick();
    for (int k = 0; k < MB; k++) begin
      reqLast = (k == MB - 1) ? 4'b0001 : 4'b0000;
      reqData[0*DW +: DW] = 16'h0F00 + 16'(k);
      tick();
    end
    reqValid = '0; reqLast = '0; #1;
    checks++; if (busy !== 1'b0 || burstErr !== 1'b0) begin failures++; $display("FAIL maxb_last busy=%0d err=%0d exp=0,0", busy, burstErr); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_ready;
    rst = 1'b1; tick(); rst = 1'b0;
    reqValid = 4'b1111; reqLast = 4'b1111;
    for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = 16'h5000 + 16'(i);
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_ready = 4'b0001 << (k % 4);
      checks++; if (busy !== 1'b1 || grantIdx !== 2'(k % 4) || reqReady !== exp_ready || writeData !== 16'h5000 + 16'(k % 4)) begin
        failures++; $display("FAIL rr_grant%0d busy=%0d grant=%0d ready=%b data=%h exp=1,%0d,%b,%h", k, busy, grantIdx, reqReady, writeData, k % 4, exp_ready, 16'h5000 + 16'(k % 4));
      end
      tick();
      checks++; if (busy !== 1'b0 || writeEn !== 1'b0) begin failures++; $display("FAIL rr_idle%0d busy=%0d we=%0d exp=0,0", k, busy, writeEn); end
    end
  endtask

  task automatic test_reset_mid_burst;
    reqValid = 4'b1000; reqLast = 4'b0000; reqData[3*DW +: DW] = 16'h7001;
    tick();
    checks++; if (grantIdx !== 2'd3 || writeEn !== 1'b1) begin failures++; $display("FAIL rmid_w1 grant=%0d we=%0d exp=3,1", grantIdx, writeEn); end
    tick();
    reqData[3*DW +: DW] = 16'h7002; #1;
    checks++; if (writeEn !== 1'b1 || writeData !== 16'h7002) begin failures++; $display("FAIL rmid_w2 we=%0d data=%h exp=1,7002", writeEn, writeData); end
    rst = 1'b1; #1;
    checks++; if (writeEn !== 1'b0 || busy !== 1'b0 || reqReady !== 4'b0) begin failures++; $display("FAIL rmid_rst we=%0d busy=%0d ready=%b exp=0,0,0000", writeEn, busy, reqReady); end
    tick();
    rst = 1'b0; reqValid = 4'b1111; reqLast = 4'b1111; #1;
    checks++; if (writeEn !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_after we=%0d busy=%0d exp=0,0", writeEn, busy); end
    tick();
    checks++; if (busy !== 1'b1 || grantIdx !== 2'd0) begin failures++; $display("FAIL rmid_regrant busy=%0d grant=%0d exp=1,0", busy, grantIdx); end
    reqValid = '0; reqLast = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_priority();
    test_burst();
    test_full();
    test_max_burst();
    test_round_robin();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
